// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART transmitter, 8N1 (8E1 with TX_PARITY_EN), one-entry holding register
//
// Purpose: serializes bytes into start + 8 data bits (LSB first) + stop frames.
//          The bit rate comes from an external one-cycle strobe, one per bit time.
//          A one-entry holding register lets the next byte queue during a frame,
//          so back-to-back frames leave no idle gap on the line.
// Build option: define TX_PARITY_EN to add an even-parity bit between DATA and STOP.
// Ports:
//   clk       in   system clock, rising edge
//   rst       in   synchronous active-high reset
//   txen      in   bit-period strobe (one-cycle pulse per bit time)
//   tx_valid  in   byte offered on tx_data
//   tx_data   in   byte to send, sampled on the accept cycle
//   tx_ready  out  holding register empty
//   txd       out  registered serial line, idles high
//   busy      out  frame in progress
//   done      out  one-cycle pulse after a stop bit completes
module uart_tx (
    input  logic       clk,
    input  logic       rst,
    input  logic       txen,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       txd,
    output logic       busy,
    output logic       done
);

`ifdef TX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        STOP   = 3'd3,
        PARITY = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        STOP   = 3'd3
    } state_t;
`endif

    state_t     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] hold_q, hold_d;
    logic       hold_vld_q, hold_vld_d;
    logic       txd_q, txd_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       load;
`ifdef TX_PARITY_EN
    logic       par_q, par_d;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        hold_d     = hold_q;
        hold_vld_d = hold_vld_q;
        done_d     = 1'b0;
        load       = 1'b0;
`ifdef TX_PARITY_EN
        par_d      = par_q;
`endif

        // Accept only into an empty holding register; a full one ignores tx_valid.
        if (tx_valid && !hold_vld_q) begin
            hold_d     = tx_data;
            hold_vld_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (txen && hold_vld_q) begin
                    load = 1'b1;
                end
            end
            START: begin
                if (txen) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (txen) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    cnt_d   = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
`ifdef TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef TX_PARITY_EN
            PARITY: begin
                if (txen) begin
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                if (txen) begin
                    done_d = 1'b1;
                    // A queued byte starts straight away: no idle period between frames.
                    if (hold_vld_q) begin
                        load = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Load cannot coincide with an accept: it needs hold_vld_q=1, accept needs 0.
        if (load) begin
            shift_d    = hold_q;
            hold_vld_d = 1'b0;
            cnt_d      = 3'd0;
            state_d    = START;
`ifdef TX_PARITY_EN
            par_d      = ^hold_q;
`endif
        end

        // txd is registered from next-state values so each bit starts the cycle after the strobe.
        case (state_d)
            START:   txd_d = 1'b0;
            DATA:    txd_d = shift_d[0];
`ifdef TX_PARITY_EN
            PARITY:  txd_d = par_d;
`endif
            default: txd_d = 1'b1;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= 3'd0;
            shift_q    <= 8'h00;
            hold_q     <= 8'h00;
            hold_vld_q <= 1'b0;
            txd_q      <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef TX_PARITY_EN
            par_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            hold_q     <= hold_d;
            hold_vld_q <= hold_vld_d;
            txd_q      <= txd_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
`ifdef TX_PARITY_EN
            par_q      <= par_d;
`endif
        end
    end

    assign tx_ready = !hold_vld_q;
    assign txd      = txd_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - self-checking bench for uart_tx
module tb_uart_tx;

    localparam int P = 16;
`ifdef TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       txen;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;
    logic       txd;
    logic       busy;
    logic       done;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    typedef struct {
        logic [7:0] data;
        logic       par;
        int         start;
    } frame_t;

    frame_t     rxq[$];
    logic [7:0] expq[$];
    int         doneq[$];

    uart_tx dut (
        .clk      (clk),
        .rst      (rst),
        .txen     (txen),
        .tx_valid (tx_valid),
        .tx_data  (tx_data),
        .tx_ready (tx_ready),
        .txd      (txd),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Strobe is high during every cycle whose index is a multiple of P.
    initial begin
        txen = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            txen = ((cyc % P) == 0);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Reads n cycles of the line; returns mid-period value and whether it stayed constant.
    task automatic sample_bits(input int n, output logic v, output bit stable, output bit ab);
        logic first;
        first  = 1'bx;
        stable = 1'b1;
        ab     = 1'b0;
        v      = 1'bx;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (rst !== 1'b0) ab = 1'b1;
            if (i == 0) first = txd;
            else if (txd !== first) stable = 1'b0;
            if (i == n / 2) v = txd;
        end
    endtask

    // Line-level receiver model: frames are decoded purely from txd timing.
    initial begin : decoder
        logic       v;
        bit         st;
        bit         ab;
        logic [7:0] d;
        logic       p;
        int         s;
        frame_t     f;
        forever begin
            @(negedge clk);
            if (rst !== 1'b0 || txd !== 1'b0) continue;
            s = cyc;
            sample_bits(P - 1, v, st, ab);
            if (ab) continue;
            check("start_bit", {30'd0, st, v}, 32'h2);
            check("start_align", s % P, 1);
            d = 8'h00;
            for (int i = 0; i < 8; i++) begin
                sample_bits(P, v, st, ab);
                if (ab) break;
                d[i] = v;
                check("data_stable", {31'd0, st}, 1);
            end
            if (ab) continue;
`ifdef TX_PARITY_EN
            sample_bits(P, v, st, ab);
            if (ab) continue;
            p = v;
            check("par_stable", {31'd0, st}, 1);
            check("par_even", {31'd0, p}, $countones(d) % 2);
`else
            p = 1'b0;
`endif
            sample_bits(P, v, st, ab);
            if (ab) continue;
            check("stop_bit", {30'd0, st, v}, 32'h3);
            f.data  = d;
            f.par   = p;
            f.start = s;
            rxq.push_back(f);
        end
    end

    initial begin : done_mon
        forever begin
            @(negedge clk);
            if (done === 1'b1) doneq.push_back(cyc);
        end
    end

    task automatic send(input logic [7:0] b);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if (tx_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("send_wait", {31'd0, ok}, 1);
        tx_valid = 1'b1;
        tx_data  = b;
        expq.push_back(b);
        @(negedge clk);
        tx_valid = 1'b0;
        tx_data  = 8'($urandom);
        check("ready_fall", {31'd0, tx_ready}, 0);
    endtask

    task automatic wait_busy(input logic val, input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if (busy === val) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check(tag, {31'd0, ok}, 1);
    endtask

    task automatic wait_idle(input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 8000; i++) begin
            if (busy === 1'b0 && tx_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check(tag, {31'd0, ok}, 1);
    endtask

    initial begin : main
        int n, d0, r0, s, rc, k;
        bit ok;

        rst      = 1'b1;
        tx_valid = 1'b0;
        tx_data  = 8'h00;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_txd", {31'd0, txd}, 1);
        check("rst_ready", {31'd0, tx_ready}, 1);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_done", {31'd0, done}, 0);
        rst = 1'b0;

        // Idle strobes with nothing queued do nothing
        repeat (2 * P) @(negedge clk);
        check("idle_noop_txd", {31'd0, txd}, 1);
        check("idle_noop_busy", {31'd0, busy}, 0);

        // Single frame 0x55
        d0 = doneq.size();
        r0 = rxq.size();
        send(8'h55);
        wait_busy(1'b1, "t1_busy_rise");
        n = 0;
        while (busy === 1'b1 && n < 2000) begin
            n++;
            @(negedge clk);
        end
        check("busy_len", n, P * NB);
        check("done_with_busy_fall", {31'd0, done}, 1);
        check("t1_idle_txd", {31'd0, txd}, 1);
        check("t1_idle_ready", {31'd0, tx_ready}, 1);
        check("t1_done_count", doneq.size() - d0, 1);
        check("t1_frame_count", rxq.size() - r0, 1);
        if (rxq.size() > r0) check("t1_data", rxq[r0].data, 8'h55);

        // Back-to-back: 0xA5 then 0x3C offered during DATA
        wait_idle("t2_idle");
        d0 = doneq.size();
        r0 = rxq.size();
        send(8'hA5);
        wait_busy(1'b1, "t2_busy_rise");
        repeat (3 * P) @(negedge clk);
        check("t2_ready_in_data", {31'd0, tx_ready}, 1);
        send(8'h3C);
        wait_idle("t2_drain");
        check("t2_done_count", doneq.size() - d0, 2);
        if (doneq.size() >= d0 + 2) check("t2_done_gap", doneq[d0 + 1] - doneq[d0], P * NB);
        check("t2_frame_count", rxq.size() - r0, 2);
        if (rxq.size() >= r0 + 2) check("t2_no_idle_gap", rxq[r0 + 1].start - rxq[r0].start, P * NB);

        // Hold tx_valid with 0xFF while shifter and holding register are full
        r0 = rxq.size();
        send(8'h11);
        wait_busy(1'b1, "t3_busy_rise");
        send(8'h22);
        tx_valid = 1'b1;
        tx_data  = 8'hFF;
        ok = 1'b0;
        rc = 0;
        for (int i = 0; i < 4000; i++) begin
            if (tx_ready === 1'b1) begin
                ok = 1'b1;
                rc = cyc;
                break;
            end
            @(negedge clk);
        end
        check("t3_ready_rise", {31'd0, ok}, 1);
        check("t3_ready_align", rc % P, 1);
        @(negedge clk);
        tx_valid = 1'b0;
        expq.push_back(8'hFF);
        check("t3_ff_accepted", {31'd0, tx_ready}, 0);
        wait_idle("t3_drain");
        check("t3_frame_count", rxq.size() - r0, 3);
        if (rxq.size() >= r0 + 2) check("t3_drain_start", rxq[r0 + 1].start, rc);

        // Reset during DATA bit 3 of 0x0F, with 0x99 queued behind it
        d0 = doneq.size();
        r0 = rxq.size();
        send(8'h0F);
        wait_busy(1'b1, "t4_busy_rise");
        s = cyc;
        send(8'h99);
        void'(expq.pop_back());
        void'(expq.pop_back());
        for (int i = 0; i < 4000; i++) begin
            if (cyc >= s + 4 * P + 6) break;
            @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        check("t4_rst_txd", {31'd0, txd}, 1);
        check("t4_rst_busy", {31'd0, busy}, 0);
        check("t4_rst_ready", {31'd0, tx_ready}, 1);
        check("t4_rst_done", {31'd0, done}, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (12 * P) @(negedge clk);
        check("t4_no_done", doneq.size() - d0, 0);
        check("t4_no_frame", rxq.size() - r0, 0);
        send(8'h81);
        wait_idle("t4_after");
        check("t4_done_count", doneq.size() - d0, 1);
        check("t4_frame_count", rxq.size() - r0, 1);
        if (rxq.size() > r0) check("t4_data", rxq[r0].data, 8'h81);

        // tx_valid coincident with the strobe from idle
        r0 = rxq.size();
        ok = 1'b0;
        for (int i = 0; i <= 2 * P; i++) begin
            if ((cyc % P) == 0) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("t5_find_strobe", {31'd0, ok}, 1);
        k = cyc;
        tx_valid = 1'b1;
        tx_data  = 8'hC3;
        expq.push_back(8'hC3);
        @(negedge clk);
        tx_valid = 1'b0;
        check("t5_no_start", {31'd0, txd}, 1);
        wait_busy(1'b1, "t5_busy_rise");
        wait_idle("t5_drain");
        check("t5_frame_count", rxq.size() - r0, 1);
        if (rxq.size() > r0) check("t5_start_cycle", rxq[r0].start, k + P + 1);

`ifdef TX_PARITY_EN
        r0 = rxq.size();
        send(8'h07);
        send(8'h03);
        wait_idle("par_drain");
        check("par_frame_count", rxq.size() - r0, 2);
        if (rxq.size() >= r0 + 2) begin
            check("par_07", {31'd0, rxq[r0].par}, 1);
            check("par_03", {31'd0, rxq[r0 + 1].par}, 0);
        end
`endif

        // Random bytes with random gaps
        for (int j = 0; j < 24; j++) begin
            repeat ($urandom_range(0, 3 * P)) @(negedge clk);
            send(8'($urandom));
        end
        wait_idle("rand_drain");
        repeat (P) @(negedge clk);

        // Whole-run scoreboard
        check("frame_total", rxq.size(), expq.size());
        check("done_total", doneq.size(), expq.size());
        for (int i = 0; i < expq.size() && i < rxq.size(); i++) begin
            check("frame_data", rxq[i].data, expq[i]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
